// File: rtl/pc_pkg.sv
// Shared definitions for the PC / return-address-stack unit.
//   pc_op_e       : operation encoding on pc_op (unlisted codes act as HOLD)
//   INSTR_BYTES   : sequential PC increment / return-address offset
//   is_misaligned : true when a redirect target is not instruction aligned
package pc_pkg;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100,
    OP_HOLD   = 3'b101
  } pc_op_e;

  localparam int INSTR_BYTES = 4;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular LIFO return-address stack.
//   clk, rst    : clock, async active-high reset (count/pointer cleared)
//   push, pop   : one operation per cycle; push wins if both asserted;
//                 pop on an empty stack is ignored
//   push_data   : value written on push
//   top         : newest entry, 0 when empty
//   count       : number of valid entries (0..DEPTH)
//   ovf         : combinational, this cycle's push overwrites the oldest entry
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count,
  output logic            ovf
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;   // slot the next push writes
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   top_idx;
  logic            full;

  assign full    = (cnt == CW'(DEPTH));
  assign top_idx = wr_ptr - PW'(1);
  assign top     = (cnt == '0) ? '0 : mem[top_idx];
  assign count   = cnt;
  assign ovf     = push && full;

  // When full, wr_ptr also points at the oldest entry, so a push there is
  // exactly the circular overwrite; the pointer wraps naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && cnt != '0) begin
      wr_ptr <= wr_ptr - PW'(1);
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with return-address stack.
//   clk, rst     : clock, async active-high reset
//   stall        : hold all state, suppress pulses
//   pc_op        : SEQ/JUMP/BRANCH/CALL/RET/HOLD (pc_pkg::pc_op_e)
//   target_addr  : absolute target, or signed byte offset for BRANCH
//   pc_out       : current PC (register)
//   ras_top      : address the next RET would pop, 0 when empty
//   ras_count    : valid stack entries
//   ras_ovf      : pulse, a CALL overwrote the oldest stack entry
//   ras_unf      : pulse, RET on empty stack took target_addr
//   misalign     : pulse, redirect rejected because target bits[1:0] != 0
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [2:0]                 pc_op,
  input  logic [XLEN-1:0]            target_addr,
  output logic [XLEN-1:0]            pc_out,
  output logic [XLEN-1:0]            ras_top,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_ovf,
  output logic                       ras_unf,
  output logic                       misalign
);

  logic [XLEN-1:0] pc_q, pc_nxt, cand, seq_pc;
  logic            push, pop, stack_ovf;
  logic            unf_nxt, mis_nxt;

  assign seq_pc = pc_q + XLEN'(INSTR_BYTES);

  ras_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .count     (ras_count),
    .ovf       (stack_ovf)
  );

  // Redirect candidates are validated before anything is committed, so a
  // misaligned CALL never pushes and a misaligned fallback RET never flags unf.
  always_comb begin
    pc_nxt  = pc_q;
    cand    = target_addr;
    push    = 1'b0;
    pop     = 1'b0;
    unf_nxt = 1'b0;
    mis_nxt = 1'b0;
    if (!stall) begin
      case (pc_op)
        OP_SEQ: pc_nxt = seq_pc;
        OP_JUMP, OP_BRANCH: begin
          if (pc_op == OP_BRANCH) cand = pc_q + target_addr;  // two's-complement wrap
          if (is_misaligned(cand[1:0])) mis_nxt = 1'b1;
          else                          pc_nxt  = cand;
        end
        OP_CALL: begin
          if (is_misaligned(cand[1:0])) mis_nxt = 1'b1;
          else begin
            pc_nxt = cand;
            push   = 1'b1;
          end
        end
        OP_RET: begin
          if (ras_count != '0) begin
            pc_nxt = ras_top;
            pop    = 1'b1;
          end else if (is_misaligned(cand[1:0])) begin
            mis_nxt = 1'b1;
          end else begin
            pc_nxt  = cand;
            unf_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_VECTOR;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc_q     <= pc_nxt;
      ras_ovf  <= stack_ovf;
      ras_unf  <= unf_nxt;
      misalign <= mis_nxt;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
module tb_pc_ras_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  pc_op = 3'b011;
  logic [31:0] target_addr = 32'h500;
  logic [31:0] pc_out, ras_top;
  logic [2:0]  ras_count;
  logic        ras_ovf, ras_unf, misalign;

  pc_ras_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_op       (pc_op),
    .target_addr (target_addr),
    .pc_out      (pc_out),
    .ras_top     (ras_top),
    .ras_count   (ras_count),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: PC as a number, stack as a queue (newest at back).
  logic [31:0] m_pc;
  logic [31:0] stk[$];
  logic        e_ovf, e_unf, e_mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc_out,    m_pc);
    chk({tag, ".count"}, ras_count, stk.size());
    chk({tag, ".top"},   ras_top,   stk.size() ? stk[$] : 32'h0);
    chk({tag, ".ovf"},   ras_ovf,   e_ovf);
    chk({tag, ".unf"},   ras_unf,   e_unf);
    chk({tag, ".mis"},   misalign,  e_mis);
  endtask

  task automatic model_reset();
    m_pc = RV;
    stk.delete();
    e_ovf = 0; e_unf = 0; e_mis = 0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [31:0] tgt, input logic stl);
    logic [31:0] nxt;
    e_ovf = 0; e_unf = 0; e_mis = 0;
    if (!stl) begin
      case (op)
        3'd0: m_pc = m_pc + 32'd4;
        3'd1: if (tgt % 4 != 0) e_mis = 1; else m_pc = tgt;
        3'd2: begin
          nxt = m_pc + tgt;
          if (nxt % 4 != 0) e_mis = 1; else m_pc = nxt;
        end
        3'd3: begin
          if (tgt % 4 != 0) e_mis = 1;
          else begin
            if (stk.size() == DEPTH) begin
              void'(stk.pop_front());
              e_ovf = 1;
            end
            stk.push_back(m_pc + 32'd4);
            m_pc = tgt;
          end
        end
        3'd4: begin
          if (stk.size() > 0) m_pc = stk.pop_back();
          else if (tgt % 4 != 0) e_mis = 1;
          else begin
            m_pc  = tgt;
            e_unf = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic [2:0] op, input logic [31:0] tgt,
                      input logic stl = 1'b0);
    pc_op = op; target_addr = tgt; stall = stl;
    model_step(op, tgt, stl);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all("rst");
  endtask

  initial begin
    model_reset();
    // Async reset with CALL pending; held across two edges.
    #2 rst = 1'b1;
    #1 check_all("rst_async0");
    @(posedge clk); @(posedge clk); #1;
    check_all("rst_hold");
    rst = 1'b0;

    // Reset / SEQ
    step("seq1", 3'd0, 32'h0);
    step("seq2", 3'd0, 32'h0);
    step("seq3", 3'd0, 32'h0);
    chk("seq3.exact", pc_out, 32'h10C);

    // Branch wrap
    step("j8",    3'd1, 32'h8);
    step("bwrap", 3'd2, 32'hFFFF_FFF4);
    chk("bwrap.exact", pc_out, 32'hFFFF_FFFC);
    step("seqwrap", 3'd0, 32'h0);
    chk("seqwrap.exact", pc_out, 32'h0);

    // Call/return nesting
    step("j20",   3'd1, 32'h20);
    step("call1", 3'd3, 32'h400);
    step("call2", 3'd3, 32'h800);
    step("ret1",  3'd4, 32'h0);
    chk("ret1.exact", pc_out, 32'h404);
    step("ret2",  3'd4, 32'h0);
    chk("ret2.exact", pc_out, 32'h24);

    // Overflow / underflow
    for (int i = 0; i < 5; i++) step($sformatf("ovc%0d", i), 3'd3, 32'h1000 + 32'(i) * 32'h100);
    chk("ovf5.exact", ras_ovf, 1'b1);
    for (int i = 0; i < 4; i++) step($sformatf("ovr%0d", i), 3'd4, 32'h0);
    step("unf", 3'd4, 32'h40);
    chk("unf.exact", {ras_unf, pc_out}, {1'b1, 32'h40});
    step("after_unf", 3'd0, 32'h0);

    // Misalign, stall, HOLD codes
    step("jmis",    3'd1, 32'h102);
    step("bmis",    3'd2, 32'h2);
    step("cmis",    3'd3, 32'h203);
    step("rmis",    3'd4, 32'h41);
    step("cstall",  3'd3, 32'h300, 1'b1);
    step("ok",      3'd3, 32'h300);
    step("rstall",  3'd4, 32'h0, 1'b1);
    step("hold5",   3'd5, 32'h77);
    step("hold6",   3'd6, 32'h77);
    step("hold7",   3'd7, 32'h77);

    // Async reset mid-CALL with three entries
    do_reset();
    for (int i = 0; i < 3; i++) step($sformatf("pre%0d", i), 3'd3, 32'h2000 + 32'(i) * 32'h10);
    pc_op = 3'd3; target_addr = 32'h600;
    #1 rst = 1'b1;
    model_reset();
    #1 check_all("rst_mid");
    #1 rst = 1'b0;
    step("post_rst", 3'd0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  op;
      logic [31:0] tgt;
      logic        stl;
      op  = 3'($urandom_range(0, 7));
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if (op == 3'd2 && $urandom_range(0, 1) == 1) tgt = 32'($signed(32'h0)) - 32'($urandom_range(0, 64) * 4);
      stl = ($urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", i), op, tgt, stl);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 Parameter XLEN, default 32, address width in bits (16..64).
REQ-002 Parameter RESET_VECTOR, default 0, PC value after reset; SHALL be 4-byte aligned.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >= 2.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port stall  input  1  when 1, all state is held regardless of pc_op.
REQ-007 Port pc_op  input  3  operation select (see REQ-015).
REQ-008 Port target_addr  input  XLEN  absolute target (JUMP/CALL/RET fallback) or signed byte offset (BRANCH).
REQ-009 Port pc_out  output  XLEN  current program counter (register).
REQ-010 Port ras_top  output  XLEN  value the next RET would pop; 0 when the stack is empty.
REQ-011 Port ras_count  output  $clog2(RAS_DEPTH)+1  number of valid stack entries.
REQ-012 Port ras_ovf  output  1  registered one-cycle pulse: a CALL overwrote the oldest entry.
REQ-013 Port ras_unf  output  1  registered one-cycle pulse: a RET executed on an empty stack.
REQ-014 Port misalign  output  1  registered one-cycle pulse: a redirect was rejected for misalignment.

Function
REQ-015 pc_op encoding: 000 SEQ, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101 HOLD; 110/111 SHALL behave as HOLD.
REQ-016 SEQ: pc_out <= pc_out + 4.
REQ-017 JUMP: pc_out <= target_addr.
REQ-018 BRANCH: pc_out <= pc_out + $signed(target_addr).
REQ-019 CALL: push pc_out + 4 onto the stack, then pc_out <= target_addr, both on the same edge.
REQ-020 RET on a non-empty stack: pc_out <= ras_top; pop one entry.
REQ-021 RET on an empty stack: pc_out <= target_addr; stack unchanged; ras_unf = 1 for one cycle.
REQ-022 CALL on a full stack (ras_count == RAS_DEPTH): overwrite the oldest entry (circular); ras_count stays RAS_DEPTH; ras_ovf = 1 for one cycle.
REQ-023 Resolved next PC for JUMP, BRANCH, CALL and fallback RET with bits[1:0] != 0: pc_out and stack unchanged; misalign = 1 for one cycle; no ras_ovf/ras_unf pulse.
REQ-024 All PC arithmetic SHALL wrap modulo 2^XLEN; wrap is not an error.
REQ-025 Latency: an operation sampled at edge N is visible on pc_out, ras_* and status outputs after edge N; no combinational input-to-output path.
REQ-026 stall = 1: no PC, stack or count change, and all pulses = 0, for every pc_op.
REQ-027 Pulse outputs SHALL be 0 in any cycle not caused by the condition they report.

Reset
REQ-028 rst asserted: immediately pc_out = RESET_VECTOR, ras_count = 0, ras_top = 0, ras_ovf = ras_unf = misalign = 0; stack contents are don't-care.
REQ-029 Reset asserted mid-operation overrides any pc_op or stall on that edge; the first operation is sampled on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package pc_pkg SHALL hold the pc_op enum, INSTR_BYTES = 4 and the alignment-check function.
REQ-031 The return address stack SHALL be sub-module ras_stack (circular LIFO with push, pop, top, count and overflow outputs) instantiated once.
REQ-032 No latches; a single clocked process per module owns its state.

Verification
REQ-033 Reset/SEQ: rst pulse, then 3x SEQ with RESET_VECTOR = 0x100 -> pc_out 0x100, 0x104, 0x108, 0x10C.
REQ-034 Branch wrap: pc_out = 0x8, BRANCH target 0xFFFFFFF4 (-12) -> pc_out = 0xFFFFFFFC; then SEQ -> 0x0.
REQ-035 Call/return nesting: at pc_out = 0x20, CALL 0x400, then CALL 0x800, RET, RET -> pc_out 0x400, 0x800, 0x404, 0x24; ras_count 1, 2, 1, 0.
REQ-036 Overflow/underflow, RAS_DEPTH = 4: 5 CALLs -> ras_ovf pulses on the 5th only; 4 RETs return the newest 4; 5th RET with target 0x40 -> pc_out = 0x40 and ras_unf pulse.
REQ-037 Misalign/stall: JUMP 0x102 -> pc_out unchanged, misalign pulse; CALL with stall = 1 -> no change and ras_count unchanged.
REQ-038 Async reset mid-CALL: assert rst between edges with ras_count = 3 -> pc_out = RESET_VECTOR and ras_count = 0 before the next edge.
